lifo_stack: RTL and testbench
=============================

Name: lifo_stack

Overview:
Parametrised successor to the CPU's fixed 8-bit call/data stack. Configurable word width and depth, with the following behaviour:
- simultaneous push+pop (replace-top) semantics
- full/empty status and occupancy count
- sticky overflow/underflow error flags
- combinational top-of-stack peek

Sits beside the ALU and GPR file and is driven by the decoder's push/pop strobes.

Parameters:
DATA_W, 8, word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
PTR_W, $clog2(DEPTH), localparam, not overridable; count is PTR_W+1 bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
push_enable  input  1  push request this cycle
push_data  input  DATA_W  word to push
pop_enable  input  1  pop request this cycle
pop_data  output  DATA_W  registered result of last accepted pop
top_data  output  DATA_W  combinational peek of top entry; 0 when empty
count  output  PTR_W+1  current occupancy, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
err_clear  input  1  clears sticky error flags
overflow  output  1  sticky: push dropped while full
underflow  output  1  sticky: pop refused while empty

Behaviour:
- One clock domain. Reset is asynchronous and active-high on rst (clock port clk). On reset assertion: count=0, pop_data=0, overflow=0, underflow=0, empty=1, full=0. Storage array is not reset. Reset mid-operation discards all contents and any in-flight request.
- pop_data latency is 1 cycle: updated at the edge where a pop is accepted, then held until the next accepted pop.
- top_data = mem[count-1] when count>0, else 0. No added latency; reflects the post-edge state.
- Per-edge action, by (push, pop, state):
  - push only, not full: mem[count] <= push_data; count+1.
  - push only, full: push dropped; storage and count unchanged; overflow <= 1.
  - pop only, not empty: pop_data <= mem[count-1]; count-1.
  - pop only, empty: pop_data unchanged; underflow <= 1.
  - push+pop, not empty (full included): pop_data <= old top; mem[count-1] <= push_data; count unchanged; no error.
  - push+pop, empty: pass-through, pop_data <= push_data; count stays 0; no error.
  - neither: hold.
- err_clear=1 clears overflow and underflow at the edge. If an error event occurs on the same edge, set wins.
- count arithmetic is PTR_W+1 bits and never wraps; write/read index uses the low PTR_W bits.

Optional Feature:
Macro LIFO_STACK_WATERMARK_EN.
- Defined: adds output hwm [PTR_W+1] = maximum count reached since reset or since last err_clear. Reset value 0. On err_clear, hwm loads the current post-edge count. Updates in the same cycle the count rises.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package cpu_pkg holds:
  - shared default DATA_W (8)
  - a 2-bit stack op encoding (OP_NONE, OP_PUSH, OP_POP, OP_REPL) used internally and by the decoder
- One sub-module, lifo_stack_mem: DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port.
- Control, count and flags stay in lifo_stack.

Test Plan:
- DEPTH=4, DATA_W=8. After reset, push 0x11,0x22,0x33,0x44 -> count=4, full=1, top_data=0x44. A 5th push of 0x55 -> overflow=1, count=4, top_data=0x44.
- From full, pop four times -> pop_data 0x44,0x33,0x22,0x11 on the cycle after each pop, empty=1. A 5th pop -> underflow=1, pop_data stays 0x11.
- Count=2 (0x11,0x22), assert push+pop with 0xAA -> pop_data=0x22, top_data=0xAA, count=2, no flags.
- Empty, assert push+pop with 0x5C -> pop_data=0x5C, count=0, empty=1, underflow=0.
- overflow=1, assert err_clear while pushing into a full stack -> overflow stays 1. err_clear alone on the next cycle -> overflow=0.
- Assert rst asynchronously mid-cycle with count=3 -> count=0, pop_data=0, flags 0 immediately, before the next clock edge. With LIFO_STACK_WATERMARK_EN, hwm=0 after reset, and hwm=3 after three pushes then two pops.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Definitions shared by the CPU datapath blocks. These are the default data
//   word width and the stack operation encoding. The instruction decoder and
//   lifo_stack both use the encoding.
//
//   Contents:
//     CPU_DATA_W       default datapath word width (8 bits)
//     stack_op_e       2-bit stack operation {pop, push}
//     stack_op_decode  packs the decoder's push/pop strobes into stack_op_e
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_DATA_W = 8;

    // Bit 0 is push and bit 1 is pop. OP_REPL means both strobes are active
    // in the same cycle. The stack treats that as replacing the top entry.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_REPL = 2'b11
    } stack_op_e;

    function automatic stack_op_e stack_op_decode(input logic push, input logic pop);
        return stack_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// ----------------------------------------------------------------------------
// lifo_stack_mem
//   DEPTH x DATA_W register array for lifo_stack. It has one synchronous
//   write port and one asynchronous (combinational) read port.
//
//   Ports:
//     clk      in   system clock, rising edge
//     wr_en    in   write strobe
//     wr_addr  in   write index
//     wr_data  in   write word
//     rd_addr  in   read index
//     rd_data  out  mem[rd_addr], combinational
// ----------------------------------------------------------------------------
module lifo_stack_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset. Its contents only become visible through
    // count, so stale words are never observable. Leaving out the reset also
    // lets synthesis map the array to plain flops or LUT-RAM without reset
    // logic.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment. Every reader
        // then sees the pre-edge value, whatever order the blocks are
        // evaluated in.
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lifo_stack.sv
// ----------------------------------------------------------------------------
// lifo_stack
//   Parametrised LIFO stack for the CPU call/data stack. It provides:
//     - replace-top when push and pop are requested together
//     - full/empty status and an occupancy count
//     - sticky overflow/underflow flags
//     - a combinational top-of-stack peek
//
//   Optional feature (macro LIFO_STACK_WATERMARK_EN):
//     Adds the output hwm. It holds the highest count reached since reset or
//     since the last err_clear.
//
//   Parameters:
//     DATA_W  word width (>= 1)
//     DEPTH   number of entries, a power of two (>= 2)
//
//   Ports:
//     clk          in   system clock, rising edge
//     rst          in   asynchronous, active-high reset
//     push_enable  in   push request this cycle
//     push_data    in   word to push
//     pop_enable   in   pop request this cycle
//     pop_data     out  registered result of the last accepted pop
//     top_data     out  combinational peek of the top entry, 0 when empty
//     count        out  occupancy 0..DEPTH, PTR_W+1 bits
//     empty        out  count == 0
//     full         out  count == DEPTH
//     err_clear    in   clears the sticky error flags
//     overflow     out  sticky: a push was dropped while full
//     underflow    out  sticky: a pop was refused while empty
//     hwm          out  high-water mark (only with LIFO_STACK_WATERMARK_EN)
// ----------------------------------------------------------------------------
module lifo_stack
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_enable,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop_enable,
    output logic [DATA_W-1:0]      pop_data,
    output logic [DATA_W-1:0]      top_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    input  logic                   err_clear,
    output logic                   overflow,
    output logic                   underflow
`ifdef LIFO_STACK_WATERMARK_EN
    ,
    output logic [$clog2(DEPTH):0] hwm
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);

    stack_op_e         op;
    logic [PTR_W-1:0]  top_idx;
    logic [DATA_W-1:0] top_word;

    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [PTR_W:0]    count_next;
    logic [DATA_W-1:0] pop_data_next;
    logic              overflow_evt;
    logic              underflow_evt;

    assign op = stack_op_decode(push_enable, pop_enable);

    // Index of the current top entry. This uses only the low PTR_W bits.
    // When full, the low bits of count are 0, so the result wraps to
    // DEPTH-1, which is the correct top slot. When empty, the result is
    // meaningless, and top_data masks it below.
    assign top_idx = count[PTR_W-1:0] - IDX_ONE;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    lifo_stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (mem_waddr),
        .wr_data (mem_wdata),
        .rd_addr (top_idx),
        .rd_data (top_word)
    );

    assign top_data = empty ? '0 : top_word;

    always_comb begin
        // NOTE: every output of this block gets a default before the case
        // statement. No path can leave a signal unassigned, so no latch is
        // inferred.
        count_next    = count;
        pop_data_next = pop_data;
        mem_we        = 1'b0;
        mem_waddr     = count[PTR_W-1:0];
        mem_wdata     = push_data;
        overflow_evt  = 1'b0;
        underflow_evt = 1'b0;

        case (op)
            OP_PUSH: begin
                if (full) begin
                    overflow_evt = 1'b1;
                end else begin
                    mem_we     = 1'b1;
                    count_next = count + CNT_ONE;
                end
            end
            OP_POP: begin
                if (empty) begin
                    underflow_evt = 1'b1;
                end else begin
                    pop_data_next = top_word;
                    count_next    = count - CNT_ONE;
                end
            end
            OP_REPL: begin
                if (empty) begin
                    // There is nothing to replace, so the pushed word passes
                    // straight through to pop_data.
                    pop_data_next = push_data;
                end else begin
                    // The asynchronous read returns the old top this cycle.
                    // The new word overwrites that same slot at the edge.
                    pop_data_next = top_word;
                    mem_we        = 1'b1;
                    mem_waddr     = top_idx;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            pop_data  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_next;
            pop_data  <= pop_data_next;
            // If an error occurs on the same edge as err_clear, the error
            // wins.
            overflow  <= (overflow  & ~err_clear) | overflow_evt;
            underflow <= (underflow & ~err_clear) | underflow_evt;
        end
    end

`ifdef LIFO_STACK_WATERMARK_EN
    // The mark tracks the post-edge count, so it rises on the same edge as
    // count does. On err_clear it restarts from the post-edge count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm <= '0;
        end else if (err_clear) begin
            hwm <= count_next;
        end else if (count_next > hwm) begin
            hwm <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// ----------------------------------------------------------------------------
// tb_lifo_stack
//   Directed bench for lifo_stack with DEPTH=4 and DATA_W=8. Each stimulus
//   cycle queues the hand-computed post-edge state. A monitor compares that
//   state against the DUT on the falling edge after the operation's clock
//   edge.
// ----------------------------------------------------------------------------
module tb_lifo_stack;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       push_enable;
    logic [7:0] push_data;
    logic       pop_enable;
    logic [7:0] pop_data;
    logic [7:0] top_data;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       err_clear;
    logic       overflow;
    logic       underflow;
`ifdef LIFO_STACK_WATERMARK_EN
    logic [2:0] hwm;
`endif

    typedef struct {
        string      name;
        logic [7:0] pd;
        logic [7:0] top;
        logic [2:0] cnt;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       unf;
        logic [2:0] hwm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    lifo_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push_enable (push_enable),
        .push_data   (push_data),
        .pop_enable  (pop_enable),
        .pop_data    (pop_data),
        .top_data    (top_data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .err_clear   (err_clear),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef LIFO_STACK_WATERMARK_EN
        ,
        .hwm         (hwm)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one operation for one cycle and queues the state expected after
    // that cycle's rising edge.
    task automatic apply(input string name, input bit psh, input bit pp, input bit clr,
                         input logic [7:0] d, input logic [7:0] pd, input logic [7:0] top,
                         input logic [2:0] cnt, input bit emp, input bit ful,
                         input bit ovf, input bit unf, input logic [2:0] hw);
        exp_t e;
        @(posedge clk);
        #1;
        push_enable = psh;
        pop_enable  = pp;
        err_clear   = clr;
        push_data   = d;
        e.name = name; e.pd = pd; e.top = top; e.cnt = cnt; e.emp = emp;
        e.ful = ful; e.ovf = ovf; e.unf = unf; e.hwm = hw;
        exp_q.push_back(e);
    endtask

    // Monitor: on each rising edge, take the entry queued for that edge and
    // compare it on the following falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                check({e.name, ".pop_data"},  pop_data,  e.pd);
                check({e.name, ".top_data"},  top_data,  e.top);
                check({e.name, ".count"},     count,     e.cnt);
                check({e.name, ".empty"},     empty,     e.emp);
                check({e.name, ".full"},      full,      e.ful);
                check({e.name, ".overflow"},  overflow,  e.ovf);
                check({e.name, ".underflow"}, underflow, e.unf);
`ifdef LIFO_STACK_WATERMARK_EN
                check({e.name, ".hwm"},       hwm,       e.hwm);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; push_enable = 1'b0; pop_enable = 1'b0; err_clear = 1'b0; push_data = '0;
        #3;
        check("rst.count", count, 0);
        check("rst.pop_data", pop_data, 0);
        check("rst.top_data", top_data, 0);
        check("rst.empty", empty, 1);
        check("rst.full", full, 0);
        check("rst.overflow", overflow, 0);
        check("rst.underflow", underflow, 0);
`ifdef LIFO_STACK_WATERMARK_EN
        check("rst.hwm", hwm, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        //     name     psh pp clr data   pd     top    cnt e f o u hwm
        apply("push11", 1, 0, 0, 8'h11, 8'h00, 8'h11, 1, 0, 0, 0, 0, 1);
        apply("push22", 1, 0, 0, 8'h22, 8'h00, 8'h22, 2, 0, 0, 0, 0, 2);
        apply("push33", 1, 0, 0, 8'h33, 8'h00, 8'h33, 3, 0, 0, 0, 0, 3);
        apply("push44", 1, 0, 0, 8'h44, 8'h00, 8'h44, 4, 0, 1, 0, 0, 4);
        apply("ovf55",  1, 0, 0, 8'h55, 8'h00, 8'h44, 4, 0, 1, 1, 0, 4);
        apply("pop1",   0, 1, 0, 8'h00, 8'h44, 8'h33, 3, 0, 0, 1, 0, 4);
        apply("pop2",   0, 1, 0, 8'h00, 8'h33, 8'h22, 2, 0, 0, 1, 0, 4);
        apply("pop3",   0, 1, 0, 8'h00, 8'h22, 8'h11, 1, 0, 0, 1, 0, 4);
        apply("pop4",   0, 1, 0, 8'h00, 8'h11, 8'h00, 0, 1, 0, 1, 0, 4);
        apply("unf5",   0, 1, 0, 8'h00, 8'h11, 8'h00, 0, 1, 0, 1, 1, 4);
        apply("clr1",   0, 0, 1, 8'h00, 8'h11, 8'h00, 0, 1, 0, 0, 0, 0);
        apply("push11b",1, 0, 0, 8'h11, 8'h11, 8'h11, 1, 0, 0, 0, 0, 1);
        apply("push22b",1, 0, 0, 8'h22, 8'h11, 8'h22, 2, 0, 0, 0, 0, 2);
        apply("replAA", 1, 1, 0, 8'hAA, 8'h22, 8'hAA, 2, 0, 0, 0, 0, 2);
        apply("popAA",  0, 1, 0, 8'h00, 8'hAA, 8'h11, 1, 0, 0, 0, 0, 2);
        apply("pop11",  0, 1, 0, 8'h00, 8'h11, 8'h00, 0, 1, 0, 0, 0, 2);
        apply("repl5C", 1, 1, 0, 8'h5C, 8'h5C, 8'h00, 0, 1, 0, 0, 0, 2);
        apply("push01", 1, 0, 0, 8'h01, 8'h5C, 8'h01, 1, 0, 0, 0, 0, 2);
        apply("push02", 1, 0, 0, 8'h02, 8'h5C, 8'h02, 2, 0, 0, 0, 0, 2);
        apply("push03", 1, 0, 0, 8'h03, 8'h5C, 8'h03, 3, 0, 0, 0, 0, 3);
        apply("push04", 1, 0, 0, 8'h04, 8'h5C, 8'h04, 4, 0, 1, 0, 0, 4);
        apply("ovf66",  1, 0, 0, 8'h66, 8'h5C, 8'h04, 4, 0, 1, 1, 0, 4);
        apply("ovfclr", 1, 0, 1, 8'h77, 8'h5C, 8'h04, 4, 0, 1, 1, 0, 4);
        apply("clr2",   0, 0, 1, 8'h00, 8'h5C, 8'h04, 4, 0, 1, 0, 0, 4);
        apply("ovf88",  1, 0, 0, 8'h88, 8'h5C, 8'h04, 4, 0, 1, 1, 0, 4);
        apply("replful",1, 1, 0, 8'h99, 8'h04, 8'h99, 4, 0, 1, 1, 0, 4);
        apply("pop99",  0, 1, 0, 8'h00, 8'h99, 8'h03, 3, 0, 0, 1, 0, 4);
        apply("idle1",  0, 0, 0, 8'h00, 8'h99, 8'h03, 3, 0, 0, 1, 0, 4);

        // Assert reset mid-cycle with count=3. Its effect must show before
        // the next clock edge.
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst.count", count, 0);
        check("arst.pop_data", pop_data, 0);
        check("arst.top_data", top_data, 0);
        check("arst.empty", empty, 1);
        check("arst.overflow", overflow, 0);
        check("arst.underflow", underflow, 0);
`ifdef LIFO_STACK_WATERMARK_EN
        check("arst.hwm", hwm, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        apply("push10", 1, 0, 0, 8'h10, 8'h00, 8'h10, 1, 0, 0, 0, 0, 1);
        apply("push20", 1, 0, 0, 8'h20, 8'h00, 8'h20, 2, 0, 0, 0, 0, 2);
        apply("push30", 1, 0, 0, 8'h30, 8'h00, 8'h30, 3, 0, 0, 0, 0, 3);
        apply("pop30",  0, 1, 0, 8'h00, 8'h30, 8'h20, 2, 0, 0, 0, 0, 3);
        apply("pop20",  0, 1, 0, 8'h00, 8'h20, 8'h10, 1, 0, 0, 0, 0, 3);
        apply("idle2",  0, 0, 0, 8'h00, 8'h20, 8'h10, 1, 0, 0, 0, 0, 3);

        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
